// File: rtl/sr_mcycle_pkg.sv
// Shared types for the schoolRISCV multi-cycle sequencer: state and trap-cause codes.
package sr_mcycle_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RESET  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    TRAP   = 3'd4,
    HOLD   = 3'd5
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } trap_cause_t;

  // Bits needed to hold a count of 0..limit inclusive.
  function automatic int unsigned timerWidth(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sr_mcycle_ctrl_if.sv
// Sequencer-side bundle: instruction-memory handshake, decoder flags and datapath write strobes.
interface sr_mcycle_ctrl_if;

  logic imem_req;
  logic imem_ack;
  logic ir_we;
  logic pc_we;
  logic pc_sel;
  logic rf_we;
  logic dec_reg_write;
  logic dec_pc_src;
  logic dec_invalid;

  modport master (
    output imem_req,
    output ir_we,
    output pc_we,
    output pc_sel,
    output rf_we,
    input  imem_ack,
    input  dec_reg_write,
    input  dec_pc_src,
    input  dec_invalid
  );

  modport slave (
    input  imem_req,
    input  ir_we,
    input  pc_we,
    input  pc_sel,
    input  rf_we,
    output imem_ack,
    output dec_reg_write,
    output dec_pc_src,
    output dec_invalid
  );

endinterface

// File: rtl/sr_fetch_timer.sv
// Clearable saturating fetch-wait counter; hit flags the increment that reaches LIMIT.
module sr_fetch_timer
  import sr_mcycle_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int unsigned TIMER_W = timerWidth(LIMIT);

  logic [TIMER_W-1:0] cnt;

  // Combinational so the caller can trap in the same cycle the limit is reached.
  assign hit = inc && (cnt == TIMER_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != TIMER_W'(LIMIT))) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/sr_mcycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer with traps and retired-instruction counter.
// Optional single-step HOLD state and step port enabled by SR_MCYCLE_STEP_EN.
module sr_mcycle_ctrl
  import sr_mcycle_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 255,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SR_MCYCLE_STEP_EN
  input  logic               step,
`endif
  sr_mcycle_ctrl_if.master   bus,
  output logic               halted,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   instret,
  output logic [2:0]         state
);

`ifdef SR_MCYCLE_STEP_EN
  localparam state_t IDLE_STATE = HOLD;
`else
  localparam state_t IDLE_STATE = FETCH;
`endif

  state_t      stateQ;
  trap_cause_t causeQ;
  logic        inFetch;
  logic        inExec;
  logic        timerHit;

  assign inFetch = (stateQ == FETCH);
  assign inExec  = (stateQ == EXEC);

  sr_fetch_timer #(
    .LIMIT (FETCH_TIMEOUT)
  ) uFetchTimer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!inFetch),
    .inc   (inFetch && !bus.imem_ack),
    .hit   (timerHit)
  );

  // State, trap cause and retire counter; reset has priority over every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= RESET;
      causeQ  <= CAUSE_NONE;
      instret <= '0;
    end else begin
      case (stateQ)
        RESET: stateQ <= IDLE_STATE;
        FETCH: begin
          if (bus.imem_ack) begin
            stateQ <= DECODE;
          end else if (timerHit) begin
            stateQ <= TRAP;
            causeQ <= CAUSE_TIMEOUT;
          end
        end
        DECODE: begin
          if (bus.dec_invalid) begin
            stateQ <= TRAP;
            causeQ <= CAUSE_ILLEGAL;
          end else begin
            stateQ <= EXEC;
          end
        end
        EXEC: begin
          instret <= instret + CNT_W'(1);
          stateQ  <= IDLE_STATE;
        end
        TRAP: stateQ <= TRAP;
`ifdef SR_MCYCLE_STEP_EN
        HOLD: begin
          if (step) stateQ <= FETCH;
        end
`endif
        default: stateQ <= RESET;
      endcase
    end
  end

  // Strobes depend on the current state, so none can leak outside its own state.
  assign bus.imem_req = inFetch;
  assign bus.ir_we    = inFetch && bus.imem_ack;
  assign bus.pc_we    = inExec;
  assign bus.pc_sel   = inExec && bus.dec_pc_src;
  assign bus.rf_we    = inExec && bus.dec_reg_write;

  assign halted     = (stateQ == TRAP);
  assign trap_cause = causeQ;
  assign state      = stateQ;

endmodule

// File: doc/sr_mcycle_ctrl.md
# sr_mcycle_ctrl

Multi-cycle sequencer for the schoolRISCV core. Steps the shared datapath through fetch, decode and execute phases around the instruction decoder, using a req/ack handshake to instruction memory. Gates PC, IR and register-file write enables, traps on illegal instructions or fetch timeout, and counts retired instructions. Sits in `sr_cpu` between instruction memory, the decoder and the PC/IR/regfile write ports.

## Interface
- `FETCH_TIMEOUT`, default 255: maximum cycles spent in FETCH without ack before a timeout trap; legal range 1..65535.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1: clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `imem_ack`  in  1: instruction memory data valid this cycle; ignored outside FETCH.
- `dec_reg_write`  in  1: `regWrite` from the decoder.
- `dec_pc_src`  in  1: `pcSrc` from the decoder (1 = branch target).
- `dec_invalid`  in  1: `invalid_instr` from the decoder.
- `step`  in  1: single-step pulse; present only with `SR_MCYCLE_STEP_EN`.
- `imem_req`  out  1: fetch request.
- `ir_we`  out  1: capture instruction memory data into IR.
- `pc_we`  out  1: update PC.
- `pc_sel`  out  1: PC source (0 = PC+4, 1 = branch target); meaningful only when `pc_we` is 1.
- `rf_we`  out  1: register-file write enable.
- `halted`  out  1: controller is in TRAP.
- `trap_cause`  out  2: 0 = none, 1 = illegal instruction, 2 = fetch timeout.
- `instret`  out  CNT_W: retired-instruction count.
- `state`  out  3: current state code, for debug.

## Operation
- States: RESET, FETCH, DECODE, EXEC, TRAP, plus HOLD with the macro only.
- RESET
  - Entered whenever `rst_n` is 0 at a clock edge.
  - All outputs are 0, `instret` is 0 and the timeout counter is 0.
  - Moves to FETCH on the first edge with `rst_n` high, or to HOLD with the macro.
- FETCH
  - `imem_req` is 1 for every cycle spent here.
  - If `imem_ack` is 1: `ir_we` is 1 in that same cycle, and the next state is DECODE.
  - If `imem_ack` is 0: the timeout counter increments.
  - When the counter reaches FETCH_TIMEOUT with no ack, the next state is TRAP with cause 2.
  - The counter clears on FETCH entry.
- DECODE
  - Single cycle, all strobes 0; the decoder and regfile read settle.
  - If `dec_invalid` is 1, the next state is TRAP with cause 1; otherwise EXEC.
- EXEC
  - Single cycle with `pc_we` = 1, `pc_sel` = `dec_pc_src` and `rf_we` = `dec_reg_write`.
  - `instret` increments by 1, modulo 2^CNT_W.
  - The next state is FETCH, or HOLD with the macro.
- TRAP
  - `halted` is 1 and `trap_cause` is held; all strobes are 0.
  - Left only by reset.
- Strobes (`imem_req`, `ir_we`, `pc_we`, `rf_we`) are decoded from state only, so none can be asserted outside its state.

## Timing
- Instruction latency is ack cycle + DECODE + EXEC; with zero-wait memory, 3 cycles per instruction.
- `imem_ack` is sampled only while `imem_req` is 1. Memory keeps data valid in the ack cycle; one ack equals one fetch.
- Ack in the same cycle the timeout count is reached: ack wins, no trap.
- `trap_cause` and `halted` become valid the cycle after the faulting DECODE or FETCH cycle.
- `instret` shows the new value the cycle after EXEC.
- `rst_n` low mid-instruction (any state): RESET on the next edge. No PC or regfile write is issued in that cycle unless EXEC was already combinationally active in the reset cycle; the integration ensures PC/regfile also reset.

## Configuration
- `SR_MCYCLE_STEP_EN` defined:
  - Adds the `step` port and the HOLD state (all strobes 0).
  - RESET and EXEC go to HOLD; HOLD goes to FETCH on the cycle `step` is 1.
  - Exactly one instruction executes per `step` pulse; `step` while not in HOLD is ignored.
- Not defined: no `step` port, no HOLD state; EXEC goes to FETCH and RESET goes to FETCH.

## Structure
- Package `sr_mcycle_pkg`:
  - `state_t` enum with explicit 3-bit codes: RESET=0, FETCH=1, DECODE=2, EXEC=3, TRAP=4, HOLD=5.
  - `trap_cause_t` with codes 0/1/2.
- Sub-module `sr_fetch_timer`: clearable saturating counter with a `hit` output at FETCH_TIMEOUT, width `$clog2(FETCH_TIMEOUT+1)`.

## Test plan
- Reset release, then ack asserted every FETCH, with the decoder driving `addi` (`dec_reg_write`=1) → `ir_we`/`pc_we`/`rf_we` pulse once each per 3 cycles; `instret` = 10 after 30 cycles.
- Ack delayed 5 cycles → `imem_req` high for 6 cycles, then DECODE; no trap.
- No ack with FETCH_TIMEOUT=4 → TRAP after 4 FETCH cycles; `halted`=1, `trap_cause`=2, strobes stay 0 for the next 20 cycles.
- `dec_invalid`=1 in DECODE → TRAP with cause 1; `pc_we` and `rf_we` never asserted; `instret` unchanged.
- Taken `beq` (`dec_pc_src`=1, `dec_reg_write`=0) → EXEC has `pc_we`=1, `pc_sel`=1, `rf_we`=0.
- `rst_n` low for 1 cycle during DECODE → next state RESET with all outputs 0 and `instret`=0. With `SR_MCYCLE_STEP_EN`: 3 `step` pulses give `instret`=3, and extra cycles in HOLD do not change it.
